// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand loader: state encoding and default operand width.
package alu_pkg;

  localparam int ALU_N = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GOT_A  = 2'd1;
  localparam logic [1:0] ST_ISSUE  = 2'd2;
  localparam logic [1:0] ST_RESULT = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    GOT_A  = ST_GOT_A,
    ISSUE  = ST_ISSUE,
    RESULT = ST_RESULT
  } state_e;

endpackage

// File: rtl/mod_counter.sv
// Free-running modulo-2^W event counter with async active-low reset; wraps silently.
module mod_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Pairs serial operand words into in0/in1 for a registered ALU, flags the result once the
// ALU has captured it, holds operands until the consumer takes it, and counts accepted pairs.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int N     = ALU_N,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [N-1:0]     s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [N-1:0]     in0,
  output logic [N-1:0]     in1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] pair_count
);

  state_e         state_q, state_d;
  logic [N-1:0]   in0_q, in0_d;
  logic [N-1:0]   in1_q, in1_d;
  logic           res_valid_q, res_valid_d;
  logic           xfer;
  logic           pair_done;

  assign s_ready   = (state_q == IDLE) || (state_q == GOT_A);
  assign xfer      = s_valid & s_ready;
  // flush outranks res_ready, so an aborted result is never counted
  assign pair_done = (state_q == RESULT) & res_ready & ~flush;

  always_comb begin
    state_d     = state_q;
    in0_d       = in0_q;
    in1_d       = in1_q;
    res_valid_d = res_valid_q;
    if (flush) begin
      state_d     = IDLE;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            in0_d   = s_data;
            state_d = GOT_A;
          end
        end
        GOT_A: begin
          if (xfer) begin
            in1_d   = s_data;
            state_d = ISSUE;
          end
        end
        // The ALU captures f(in0,in1) at the end of this single cycle
        ISSUE: begin
          state_d     = RESULT;
          res_valid_d = 1'b1;
        end
        RESULT: begin
          if (res_ready) begin
            res_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      in0_q       <= '0;
      in1_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in0_q       <= in0_d;
      in1_q       <= in1_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign in0       = in0_q;
  assign in1       = in1_q;
  assign res_valid = res_valid_q;

  mod_counter #(
    .W (CNT_W)
  ) u_pair_cnt (
    .clk_i   (clk),
    .rst_ni  (rst),
    .inc_i   (pair_done),
    .count_o (pair_count)
  );

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed and randomized checks of alu_operand_loader with a registered adder ALU downstream.
module tb_alu_operand_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [3:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] in0;
  logic [3:0] in1;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] pair_count;
  logic [3:0] alu_out;

  int vectors = 0;
  int fails   = 0;
  int exp_cnt = 0;

  logic [3:0] qa[$];
  logic [3:0] qb[$];
  logic [3:0] pend;
  bit         have_a;
  bit         sr, rv, took;
  int         acc, budget;

  always #5 clk = ~clk;

  alu_operand_loader #(.N(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .in0        (in0),
    .in1        (in1),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .pair_count (pair_count)
  );

  // Downstream ALU, OPCODE=00 (add), output registered, reset by ~rst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) alu_out <= 4'h0;
    else      alu_out <= in0 + in1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] w);
    int n;
    n = 0;
    s_data  = w;
    s_valid = 1'b1;
    while (!s_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("send_timeout", 32'd0, 32'd1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic do_pair(input logic [3:0] a, input logic [3:0] b);
    res_ready = 1'b1;
    send(a);
    send(b);
    tick();
    tick();
    exp_cnt++;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; s_data = 4'h0; s_valid = 1'b0; res_ready = 1'b0;
    tick();
    chk("rst_in0", in0, 0);
    chk("rst_in1", in1, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_count", pair_count, 0);
    chk("rst_s_ready", s_ready, 1);
    #3 rst = 1'b1;
    tick();

    // Basic pair 3 + 5 with exact latency
    res_ready = 1'b1;
    send(4'h3);
    send(4'h5);
    chk("lat_issue_rv", res_valid, 0);
    chk("lat_issue_sready", s_ready, 0);
    tick();
    chk("lat_result_rv", res_valid, 1);
    chk("basic_in0", in0, 4'h3);
    chk("basic_in1", in1, 4'h5);
    chk("basic_alu", alu_out, 4'h8);
    tick();
    exp_cnt++;
    chk("basic_rv_clear", res_valid, 0);
    chk("basic_count", pair_count, exp_cnt);
    chk("basic_sready", s_ready, 1);

    // Backpressure: result and operands held, no word taken during RESULT
    res_ready = 1'b0;
    send(4'h9);
    send(4'h4);
    tick();
    s_valid = 1'b1;
    s_data  = 4'h7;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rv", res_valid, 1);
      chk("bp_in0", in0, 4'h9);
      chk("bp_in1", in1, 4'h4);
      chk("bp_alu", alu_out, 4'hD);
      chk("bp_sready", s_ready, 0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    s_valid   = 1'b0;
    res_ready = 1'b0;
    exp_cnt++;
    chk("bp_no_accept_in0", in0, 4'h9);
    chk("bp_count", pair_count, exp_cnt);
    chk("bp_rv_clear", res_valid, 0);

    // Asynchronous reset mid-pair
    send(4'hA);
    #2 rst = 1'b0;
    #1;
    chk("arst_in0", in0, 0);
    chk("arst_in1", in1, 0);
    chk("arst_rv", res_valid, 0);
    chk("arst_count", pair_count, 0);
    chk("arst_sready", s_ready, 1);
    #1 rst = 1'b1;
    exp_cnt = 0;
    tick();

    // Overflow in the ALU, then counter wrap
    res_ready = 1'b1;
    send(4'hF);
    send(4'h2);
    tick();
    chk("ovf_alu", alu_out, 4'h1);
    tick();
    exp_cnt++;
    for (int i = 0; i < 254; i++) do_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    chk("preload_count", pair_count, 8'd255);
    do_pair(4'h1, 4'h4);
    chk("wrap_count", pair_count, 8'd0);
    exp_cnt = 0;

    // flush in GOT_A with a same-cycle word
    res_ready = 1'b0;
    send(4'h6);
    s_valid = 1'b1;
    s_data  = 4'hA;
    flush   = 1'b1;
    tick();
    flush   = 1'b0;
    s_valid = 1'b0;
    chk("flush_in0", in0, 4'h6);
    chk("flush_in1_dropped", in1, 4'h4);
    chk("flush_count", pair_count, 0);
    res_ready = 1'b1;
    send(4'h1);
    chk("flush_idle_state", s_ready, 1);
    send(4'h1);
    tick();
    chk("flush_next_alu", alu_out, 4'h2);
    chk("flush_next_rv", res_valid, 1);
    tick();
    exp_cnt++;
    chk("flush_next_count", pair_count, exp_cnt);

    // flush in RESULT outranks res_ready
    res_ready = 1'b0;
    send(4'h2);
    send(4'h3);
    tick();
    res_ready = 1'b1;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    res_ready = 1'b0;
    chk("flushres_rv", res_valid, 0);
    chk("flushres_count", pair_count, exp_cnt);
    chk("flushres_sready", s_ready, 1);
    chk("flushres_in0", in0, 4'h2);
    chk("flushres_in1", in1, 4'h3);

    // Random traffic against an in-order pair scoreboard
    have_a = 1'b0;
    acc    = 0;
    budget = 0;
    while (acc < 1000 && budget < 20000) begin
      sr        = s_ready;
      rv        = res_valid;
      s_valid   = ($urandom_range(0, 9) < 7);
      s_data    = 4'($urandom_range(0, 15));
      res_ready = ($urandom_range(0, 1) == 1);
      if (rv) begin
        chk("rnd_sready", s_ready, 0);
        if (qa.size() > 0) begin
          chk("rnd_in0", in0, qa[0]);
          chk("rnd_in1", in1, qb[0]);
          chk("rnd_alu", alu_out, 4'(qa[0] + qb[0]));
        end else begin
          chk("rnd_spurious_result", 32'd1, 32'd0);
        end
      end
      took = rv && res_ready;
      if (s_valid && sr) begin
        if (!have_a) begin
          pend   = s_data;
          have_a = 1'b1;
        end else begin
          qa.push_back(pend);
          qb.push_back(s_data);
          have_a = 1'b0;
        end
      end
      tick();
      budget++;
      if (took) begin
        if (qa.size() > 0) begin
          void'(qa.pop_front());
          void'(qb.pop_front());
        end
        acc++;
        exp_cnt++;
        chk("rnd_count", pair_count, 32'(exp_cnt % 256));
      end
    end
    s_valid   = 1'b0;
    res_ready = 1'b0;
    chk("rnd_pairs_done", acc, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
